// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-coordinate and sync bundle from the raster timing source to its consumers
interface vga_timing_gen_if;
    logic [9:0] horizontal_num;
    logic [9:0] vertical_num;
    logic       load_enable;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;
    modport master (output horizontal_num, vertical_num, load_enable, hsync, vsync, line_start, frame_start);
    modport slave  (input  horizontal_num, vertical_num, load_enable, hsync, vsync, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster counters with registered blanking, sync and line/frame strobes
module vga_timing_gen #(
    parameter int unsigned HVID     = 640,
    parameter int unsigned HFP      = 16,
    parameter int unsigned HSYNC    = 96,
    parameter int unsigned HBP      = 48,
    parameter int unsigned VVID     = 480,
    parameter int unsigned VFP      = 10,
    parameter int unsigned VSYNC    = 2,
    parameter int unsigned VBP      = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned SYNC_DLY = 1
) (
    input  logic               clk_25,
    input  logic               rst,
    input  logic               en,
    vga_timing_gen_if.master   pix
);
    localparam logic [9:0] H_VID  = 10'(HVID);
    localparam logic [9:0] H_LAST = 10'(HVID + HFP + HSYNC + HBP - 1);
    localparam logic [9:0] HS_ON  = 10'(HVID + HFP);
    localparam logic [9:0] HS_OFF = 10'(HVID + HFP + HSYNC - 1);
    localparam logic [9:0] V_VID  = 10'(VVID);
    localparam logic [9:0] V_LAST = 10'(VVID + VFP + VSYNC + VBP - 1);
    localparam logic [9:0] VS_ON  = 10'(VVID + VFP);
    localparam logic [9:0] VS_OFF = 10'(VVID + VFP + VSYNC - 1);
    localparam int         SR_W   = SYNC_DLY + 1;
    logic [9:0]      h, v, h_nxt, v_nxt;
    logic            le, ls, fs, hs_dec, vs_dec;
    logic [SR_W-1:0] hs_sr, vs_sr;
    // next raster position and the sync decode of that position, so every registered output lines up with the counters
    always_comb begin
        h_nxt  = (h == H_LAST) ? 10'd0 : h + 10'd1;
        v_nxt  = (h != H_LAST) ? v : (v == V_LAST) ? 10'd0 : v + 10'd1;
        hs_dec = (h_nxt >= HS_ON && h_nxt <= HS_OFF) ? SYNC_POL : ~SYNC_POL;
        vs_dec = (v_nxt >= VS_ON && v_nxt <= VS_OFF) ? SYNC_POL : ~SYNC_POL;
    end
    // counters, decodes and sync delay stages all advance together and freeze together when en is low
    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            h     <= '0;
            v     <= '0;
            le    <= 1'b1;
            ls    <= 1'b0;
            fs    <= 1'b0;
            hs_sr <= {SR_W{~SYNC_POL}};
            vs_sr <= {SR_W{~SYNC_POL}};
        end else if (en) begin
            h     <= h_nxt;
            v     <= v_nxt;
            le    <= !(h_nxt < H_VID && v_nxt < V_VID);
            ls    <= h_nxt == 10'd0;
            fs    <= h_nxt == 10'd0 && v_nxt == 10'd0;
            hs_sr <= SR_W'({hs_sr, hs_dec});
            vs_sr <= SR_W'({vs_sr, vs_dec});
        end
    end
    assign pix.horizontal_num = h;
    assign pix.vertical_num   = v;
    assign pix.load_enable    = le;
    assign pix.line_start     = ls;
    assign pix.frame_start    = fs;
    assign pix.hsync          = hs_sr[SYNC_DLY];
    assign pix.vsync          = vs_sr[SYNC_DLY];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed vectors into a scoreboard, checked by a negedge monitor on three configurations
module tb_vga_timing_gen;
    logic clk_25 = 1'b0;
    logic rst    = 1'b1;
    logic en     = 1'b1;
    logic en1    = 1'b1;
    always #5 clk_25 = ~clk_25;

    vga_timing_gen_if p0();
    vga_timing_gen_if p1();
    vga_timing_gen_if p2();

    vga_timing_gen u0 (.clk_25(clk_25), .rst(rst), .en(en), .pix(p0));
    vga_timing_gen #(.HVID(16), .HFP(2), .HSYNC(3), .HBP(3), .VVID(10), .VFP(2), .VSYNC(2), .VBP(3), .SYNC_DLY(0))
        u1 (.clk_25(clk_25), .rst(rst), .en(en1), .pix(p1));
    vga_timing_gen #(.SYNC_DLY(2), .SYNC_POL(1'b1))
        u2 (.clk_25(clk_25), .rst(rst), .en(en), .pix(p2));

    typedef struct {
        int          at;
        int          sel;
        string       name;
        logic [63:0] exp;
    } item_t;

    item_t sb[$];
    int    checks = 0, errors = 0, cyc = 0;
    event  sample_now;
    int    last_fs = -1, fs_gap = 0, last_ls = -1, ls_gap = 0;
    int    acc_hs = 0, acc_vs = 0, acc_le = 0, fr_hs = 0, fr_vs = 0, fr_le = 0, hs_bad = 0, vs_bad = 0;

    always @(posedge clk_25) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] snap(int h, int v, bit le, bit hs, bit vs, bit ls, bit fs);
        return 64'({10'(h), 10'(v), le, hs, vs, ls, fs});
    endfunction

    function automatic logic [63:0] obs(int sel);
        case (sel)
            0: return 64'({p0.horizontal_num, p0.vertical_num, p0.load_enable, p0.hsync, p0.vsync, p0.line_start, p0.frame_start});
            1: return 64'({p1.horizontal_num, p1.vertical_num, p1.load_enable, p1.hsync, p1.vsync, p1.line_start, p1.frame_start});
            2: return 64'({p2.horizontal_num, p2.vertical_num, p2.load_enable, p2.hsync, p2.vsync, p2.line_start, p2.frame_start});
            3: return 64'(fs_gap);
            4: return 64'(fr_hs);
            5: return 64'(fr_vs);
            6: return 64'(fr_le);
            7: return 64'(ls_gap);
            8: return 64'(hs_bad);
            default: return 64'(vs_bad);
        endcase
    endfunction

    function automatic void push(int at, int sel, string name, logic [63:0] exp);
        sb.push_back('{at, sel, name, exp});
    endfunction

    task automatic compare(input bit imm);
        logic [63:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (imm ? sb[i].at < 0 : sb[i].at == cyc) begin
                got = obs(sb[i].sel);
                checks++;
                if (got !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", sb[i].name, got, sb[i].exp);
                end
                sb.delete(i);
            end
        end
    endtask

    // measure the reduced-size instance continuously, then consume due scoreboard entries
    always @(negedge clk_25) begin
        if (!rst) begin
            if (p1.frame_start) begin
                if (last_fs >= 0) fs_gap = cyc - last_fs;
                last_fs = cyc;
                fr_hs = acc_hs; fr_vs = acc_vs; fr_le = acc_le;
                acc_hs = 0; acc_vs = 0; acc_le = 0;
            end
            if (p1.line_start) begin
                if (last_ls >= 0) ls_gap = cyc - last_ls;
                last_ls = cyc;
            end
            acc_hs += int'(!p1.hsync);
            acc_vs += int'(!p1.vsync);
            acc_le += int'(!p1.load_enable);
            hs_bad += int'(!p1.hsync != (p1.horizontal_num >= 10'd18 && p1.horizontal_num <= 10'd20));
            vs_bad += int'(!p1.vsync != (p1.vertical_num >= 10'd12 && p1.vertical_num <= 10'd13));
        end
        compare(1'b0);
    end

    always @(sample_now) compare(1'b1);

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk_25);
    endtask

    initial begin
        int c0, c1;
        repeat (2) @(negedge clk_25);
        push(cyc + 1, 0, "d0_reset", snap(0, 0, 1, 1, 1, 0, 0));
        push(cyc + 1, 1, "d1_reset", snap(0, 0, 1, 1, 1, 0, 0));
        push(cyc + 1, 2, "d2_reset", snap(0, 0, 1, 0, 0, 0, 0));
        @(negedge clk_25);
        c0 = cyc;
        rst = 1'b0;
        push(c0 + 1,    0, "d0_first",      snap(1, 0, 0, 1, 1, 0, 0));
        push(c0 + 639,  0, "d0_last_vid",   snap(639, 0, 0, 1, 1, 0, 0));
        push(c0 + 640,  0, "d0_blank",      snap(640, 0, 1, 1, 1, 0, 0));
        push(c0 + 656,  0, "d0_hs_pre",     snap(656, 0, 1, 1, 1, 0, 0));
        push(c0 + 657,  0, "d0_hs_on",      snap(657, 0, 1, 0, 1, 0, 0));
        push(c0 + 752,  0, "d0_hs_last",    snap(752, 0, 1, 0, 1, 0, 0));
        push(c0 + 753,  0, "d0_hs_off",     snap(753, 0, 1, 1, 1, 0, 0));
        push(c0 + 800,  0, "d0_line2",      snap(0, 1, 0, 1, 1, 1, 0));
        push(c0 + 1900, 0, "d0_midframe",   snap(300, 2, 0, 1, 1, 0, 0));
        push(c0 + 1,    2, "d2_first",      snap(1, 0, 0, 0, 0, 0, 0));
        push(c0 + 657,  2, "d2_hs_pre",     snap(657, 0, 1, 0, 0, 0, 0));
        push(c0 + 658,  2, "d2_hs_on",      snap(658, 0, 1, 1, 0, 0, 0));
        push(c0 + 753,  2, "d2_hs_last",    snap(753, 0, 1, 1, 0, 0, 0));
        push(c0 + 754,  2, "d2_hs_off",     snap(754, 0, 1, 0, 0, 0, 0));
        push(c0 + 1,    1, "d1_first",      snap(1, 0, 0, 1, 1, 0, 0));
        push(c0 + 18,   1, "d1_hs_on",      snap(18, 0, 1, 0, 1, 0, 0));
        push(c0 + 21,   1, "d1_hs_off",     snap(21, 0, 1, 1, 1, 0, 0));
        push(c0 + 24,   1, "d1_line2",      snap(0, 1, 0, 1, 1, 1, 0));
        push(c0 + 288,  1, "d1_vs_on",      snap(0, 12, 1, 1, 0, 1, 0));
        push(c0 + 407,  1, "d1_frame_end",  snap(23, 16, 1, 1, 1, 0, 0));
        push(c0 + 408,  1, "d1_frame_wrap", snap(0, 0, 0, 1, 1, 1, 1));
        push(c0 + 820,  3, "d1_fs_gap",     64'd408);
        push(c0 + 820,  4, "d1_hs_cycles",  64'd51);
        push(c0 + 820,  5, "d1_vs_cycles",  64'd48);
        push(c0 + 820,  6, "d1_video_cyc",  64'd160);
        push(c0 + 820,  7, "d1_ls_gap",     64'd24);
        push(c0 + 820,  8, "d1_hs_place",   64'd0);
        push(c0 + 820,  9, "d1_vs_place",   64'd0);
        push(c0 + 1224, 1, "d1_freeze_a",   snap(23, 16, 1, 1, 1, 0, 0));
        push(c0 + 1260, 1, "d1_freeze_b",   snap(23, 16, 1, 1, 1, 0, 0));
        push(c0 + 1261, 1, "d1_resume",     snap(0, 0, 0, 1, 1, 1, 1));
        push(c0 + 1262, 1, "d1_resume2",    snap(1, 0, 0, 1, 1, 0, 0));
        wait_to(c0 + 1223);
        en1 = 1'b0;
        wait_to(c0 + 1260);
        en1 = 1'b1;
        wait_to(c0 + 1900);
        #2 rst = 1'b1;
        #1;
        push(-1, 0, "d0_async_rst", snap(0, 0, 1, 1, 1, 0, 0));
        push(-1, 1, "d1_async_rst", snap(0, 0, 1, 1, 1, 0, 0));
        push(-1, 2, "d2_async_rst", snap(0, 0, 1, 0, 0, 0, 0));
        -> sample_now;
        repeat (2) @(negedge clk_25);
        c1 = cyc;
        rst = 1'b0;
        push(c1 + 1,   0, "d0_re_first",  snap(1, 0, 0, 1, 1, 0, 0));
        push(c1 + 1,   1, "d1_re_first",  snap(1, 0, 0, 1, 1, 0, 0));
        push(c1 + 656, 0, "d0_re_hs_pre", snap(656, 0, 1, 1, 1, 0, 0));
        push(c1 + 657, 0, "d0_re_hs_on",  snap(657, 0, 1, 0, 1, 0, 0));
        push(c1 + 658, 2, "d2_re_hs_on",  snap(658, 0, 1, 1, 0, 0, 0));
        wait_to(c1 + 700);
        repeat (2) @(negedge clk_25);
        foreach (sb[i]) begin
            checks++;
            errors++;
            $display("FAIL %s: got no sample expected %h", sb[i].name, sb[i].exp);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
